sigma_dac_mc: RTL and testbench

//  Multi-channel first-order sigma-delta audio DAC with a sample-rate handshake.

---
 rtl/sigma_dac_mc.sv | 154 +++++++++++++++
 tb/tb_sigma_dac_mc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_dac_mc.sv
// Multi-channel first-order sigma-delta DAC with a one-frame holding buffer and valid/ready intake.
// Define SIGMA_DAC_MC_DITHER_EN to add a 16-bit Galois LFSR dither bit into each modulator sum.
module sigma_dac_mc #(
  parameter int NBITS   = 16,
  parameter int NCH     = 2,
  parameter int CLK_DIV = 4,
  parameter int OSR     = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic                 mute_i,
  input  logic                 valid_i,
  input  logic [NCH*NBITS-1:0] data_i,
  output logic                 ready_o,
  input  logic                 underrun_clr_i,
  output logic                 underrun_o,
  output logic [NCH-1:0]       dout_o
);

  localparam int FW    = NCH * NBITS;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SMP_W = (OSR > 1) ? $clog2(OSR) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OSR - 1);
  localparam logic [NBITS-1:0] SIGN_BIT = {1'b1, {(NBITS-1){1'b0}}};

  logic [DIV_W-1:0]            div_q, div_d;
  logic [SMP_W-1:0]            smp_q, smp_d;
  logic                        ready_q, ready_d;
  logic [FW-1:0]               hold_q, hold_d;
  logic [FW-1:0]               active_q, active_d;
  logic [NCH-1:0][NBITS-1:0]   acc_q, acc_d;
  logic [NCH-1:0]              dout_q, dout_d;
  logic                        underrun_q, underrun_d;

  logic                        tick;
  logic                        boundary;
  logic                        accept;
  logic                        underrun_set;
  logic [NCH-1:0]              dith;
  logic [NCH-1:0][NBITS:0]     sum_w;

  assign tick     = enable_i && (div_q == DIV_LAST);
  assign boundary = tick && (smp_q == SMP_LAST);
  assign accept   = valid_i && ready_q;

`ifdef SIGMA_DAC_MC_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (tick) begin
      lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
    for (int c = 0; c < NCH; c++) begin
      dith[c] = lfsr_q[c % 16];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign dith = '0;
`endif

  // Tick/sample counters; disabling parks both at zero so a restart is phase-aligned.
  always_comb begin
    div_d = div_q;
    smp_d = smp_q;
    if (!enable_i) begin
      div_d = '0;
      smp_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
      if (tick) smp_d = boundary ? '0 : smp_q + SMP_W'(1);
    end
  end

  // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
  always_comb begin
    hold_d       = hold_q;
    ready_d      = ready_q;
    active_d     = active_q;
    underrun_set = 1'b0;
    if (boundary) begin
      if (!ready_q) begin
        active_d = mute_i ? '0 : hold_q;
        ready_d  = 1'b1;
      end else if (accept) begin
        active_d = mute_i ? '0 : data_i;
      end else begin
        if (mute_i) active_d = '0;
        underrun_set = 1'b1;
      end
    end else if (accept) begin
      hold_d  = data_i;
      ready_d = 1'b0;
    end
    if (underrun_clr_i)    underrun_d = 1'b0;
    else if (underrun_set) underrun_d = 1'b1;
    else                   underrun_d = underrun_q;
  end

  // Modulator: offset-binary input summed into an NBITS accumulator; the carry is the output bit.
  always_comb begin
    acc_d  = acc_q;
    dout_d = dout_q;
    sum_w  = '0;
    for (int c = 0; c < NCH; c++) begin
      sum_w[c] = {1'b0, acc_q[c]}
               + {1'b0, active_q[c*NBITS +: NBITS] ^ SIGN_BIT}
               + (NBITS+1)'(dith[c]);
      if (!enable_i) begin
        acc_d[c]  = '0;
        dout_d[c] = 1'b0;
      end else if (tick) begin
        acc_d[c]  = sum_w[c][NBITS-1:0];
        dout_d[c] = sum_w[c][NBITS];
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q      <= '0;
      smp_q      <= '0;
      ready_q    <= 1'b1;
      hold_q     <= '0;
      active_q   <= '0;
      acc_q      <= '0;
      dout_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      smp_q      <= smp_d;
      ready_q    <= ready_d;
      hold_q     <= hold_d;
      active_q   <= active_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      underrun_q <= underrun_d;
    end
  end

  assign ready_o    = ready_q;
  assign underrun_o = underrun_q;
  assign dout_o     = dout_q;

endmodule

// File: tb/tb_sigma_dac_mc.sv
// Self-checking bench for sigma_dac_mc: directed table, corner sequences and a randomized run
// compared every cycle against an arithmetic reference model.
module tb_sigma_dac_mc;

  localparam int NBITS   = 16;
  localparam int NCH     = 2;
  localparam int CLK_DIV = 4;
  localparam int OSR     = 8;
  localparam int FW      = NCH * NBITS;
  localparam int FULL    = 2 ** NBITS;
  localparam int HALF    = 2 ** (NBITS - 1);

  typedef logic [FW-1:0] frame_t;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           enable_i;
  logic           mute_i;
  logic           valid_i;
  frame_t         data_i;
  logic           ready_o;
  logic           underrun_clr_i;
  logic           underrun_o;
  logic [NCH-1:0] dout_o;

  sigma_dac_mc #(.NBITS(NBITS), .NCH(NCH), .CLK_DIV(CLK_DIV), .OSR(OSR)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .enable_i       (enable_i),
    .mute_i         (mute_i),
    .valid_i        (valid_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .underrun_clr_i (underrun_clr_i),
    .underrun_o     (underrun_o),
    .dout_o         (dout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait expired (t=%0t)", name, $time);
  endtask

  // Reference model: hold buffer as a queue, modulator as integer add/modulo.
  frame_t m_hold[$];
  int     m_div, m_smp;
  int     m_acc[NCH];
  int     m_act[NCH];
  bit     m_dout[NCH];
  bit     m_under;

  function automatic int offset_of(input int raw);
    return (raw + HALF) % FULL;
  endfunction

  task automatic m_reset();
    m_hold.delete();
    m_div = 0;
    m_smp = 0;
    m_under = 0;
    for (int c = 0; c < NCH; c++) begin
      m_acc[c] = 0; m_act[c] = 0; m_dout[c] = 0;
    end
  endtask

  task automatic m_step();
    bit     take, tick, bnd, have, uset;
    frame_t f;
    int     s;
    take = valid_i && (m_hold.size() == 0);
    uset = 0;
    if (!enable_i) begin
      m_div = 0;
      m_smp = 0;
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; m_dout[c] = 0;
      end
      if (take) m_hold.push_back(data_i);
    end else begin
      tick  = (m_div == CLK_DIV - 1);
      m_div = (m_div + 1) % CLK_DIV;
      bnd   = tick && (m_smp == OSR - 1);
      if (tick) begin
        for (int c = 0; c < NCH; c++) begin
          s = m_acc[c] + offset_of(m_act[c]);
          m_dout[c] = (s >= FULL);
          m_acc[c]  = s % FULL;
        end
        m_smp = (m_smp + 1) % OSR;
      end
      if (bnd) begin
        have = 1;
        f    = '0;
        if (m_hold.size() != 0) f = m_hold.pop_front();
        else if (take)          f = data_i;
        else begin
          have = 0; uset = 1;
        end
        for (int c = 0; c < NCH; c++) begin
          if (mute_i)    m_act[c] = 0;
          else if (have) m_act[c] = int'(f[c*NBITS +: NBITS]);
        end
      end else if (take) begin
        m_hold.push_back(data_i);
      end
    end
    if (underrun_clr_i) m_under = 0;
    else if (uset)      m_under = 1;
  endtask

  function automatic bit boundary_next();
    return enable_i && (m_div == CLK_DIV - 1) && (m_smp == OSR - 1);
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) m_reset();
      else       m_step();
    end
  end

  // Continuous comparison of all outputs against the model.
  initial begin
    logic [NCH-1:0] md;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        for (int c = 0; c < NCH; c++) md[c] = m_dout[c];
        check("model_dout", 32'(dout_o), 32'(md));
        check("model_ready", 32'(ready_o), 32'(m_hold.size() == 0));
        check("model_underrun", 32'(underrun_o), 32'(m_under));
      end
    end
  end

  typedef struct {
    logic [NBITS-1:0] ch0;
    logic [NBITS-1:0] ch1;
    int               ones0;
    int               ones1;
  } vec_t;

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!ready_o) timeout(name);
  endtask

  task automatic wait_pre_boundary(input string name);
    int n = 0;
    while (!boundary_next() && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!boundary_next()) timeout(name);
  endtask

  task automatic avoid_boundary();
    if (boundary_next()) @(negedge clk_i);
  endtask

  initial begin
    vec_t           vecs[6];
    logic [NCH-1:0] d[4];
    int             ones[NCH];
    int             cnt, n;
    frame_t         fr;

    vecs[0] = '{16'h7FFF, 16'h8000, 63, 0};
    vecs[1] = '{16'h0000, 16'h0000, 32, 32};
    vecs[2] = '{16'h4000, 16'hC000, 48, 16};
    vecs[3] = '{16'h1234, 16'hEDCC, 36, 27};
    vecs[4] = '{16'h0001, 16'hFFFF, 32, 31};
    vecs[5] = '{16'h8001, 16'h7FFE, 0, 63};

    rst_i = 1'b0; enable_i = 1'b1; mute_i = 1'b0; valid_i = 1'b0;
    data_i = '0; underrun_clr_i = 1'b0;
    #1 rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check("rst_dout", 32'(dout_o), 32'h0);
    check("rst_underrun", 32'(underrun_o), 32'h0);
    check("rst_ready", 32'(ready_o), 32'h1);

    // Idle input from reset: mid-scale 0,1,0,1 and underrun at the first boundary.
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (CLK_DIV) @(negedge clk_i);
      check($sformatf("idle_tick%0d", i), 32'(dout_o), (i % 2 == 1) ? 32'h3 : 32'h0);
    end
    repeat (CLK_DIV * (OSR - 4) - 1) @(negedge clk_i);
    check("underrun_before_boundary", 32'(underrun_o), 32'h0);
    @(negedge clk_i);
    check("underrun_at_boundary", 32'(underrun_o), 32'h1);

    // Table: load a frame, restart the modulator from acc=0, count ones over 64 ticks.
    foreach (vecs[i]) begin
      wait_ready($sformatf("vec%0d_ready", i));
      avoid_boundary();
      valid_i = 1'b1;
      data_i  = {vecs[i].ch1, vecs[i].ch0};
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (CLK_DIV * OSR + 8) @(negedge clk_i);
      enable_i = 1'b0;
      repeat (2) @(negedge clk_i);
      enable_i = 1'b1;
      for (int c = 0; c < NCH; c++) ones[c] = 0;
      for (int t = 0; t < 64; t++) begin
        repeat (CLK_DIV) @(negedge clk_i);
        for (int c = 0; c < NCH; c++) ones[c] += int'(dout_o[c]);
      end
      check($sformatf("vec%0d_ones_ch0", i), 32'(ones[0]), 32'(vecs[i].ones0));
      check($sformatf("vec%0d_ones_ch1", i), 32'(ones[1]), 32'(vecs[i].ones1));
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      valid_i        = ($urandom_range(0, 3) == 0);
      data_i         = {$urandom, $urandom};
      mute_i         = ($urandom_range(0, 15) == 0);
      underrun_clr_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) enable_i = ~enable_i;
      @(negedge clk_i);
    end
    enable_i = 1'b1; mute_i = 1'b0; valid_i = 1'b0; underrun_clr_i = 1'b0;
    repeat (2) @(negedge clk_i);

    // valid_i held high: one accept per CLK_DIV*OSR cycles, no underrun.
    valid_i = 1'b1;
    data_i  = {16'h2345, 16'hDCBA};
    underrun_clr_i = 1'b1;
    @(negedge clk_i);
    underrun_clr_i = 1'b0;
    wait_ready("stream_first_fill");
    cnt = 0;
    for (int i = 0; i < CLK_DIV * OSR * 4; i++) begin
      @(negedge clk_i);
      if (valid_i && ready_o) cnt++;
    end
    check("stream_accepts", 32'(cnt), 32'd4);
    check("stream_underrun", 32'(underrun_o), 32'h0);
    valid_i = 1'b0;

    // Bypass: hold empty, frame offered exactly at the boundary.
    repeat (CLK_DIV * OSR + 4) @(negedge clk_i);
    underrun_clr_i = 1'b1;
    @(negedge clk_i);
    underrun_clr_i = 1'b0;
    wait_pre_boundary("bypass_align");
    check("bypass_ready_before", 32'(ready_o), 32'h1);
    valid_i = 1'b1;
    data_i  = {16'h4000, 16'hC000};
    @(negedge clk_i);
    valid_i = 1'b0;
    check("bypass_ready_after", 32'(ready_o), 32'h1);
    check("bypass_underrun", 32'(underrun_o), 32'h0);

    // Mute with hold full of 0x4000: active forced to mid-scale, hold drains.
    avoid_boundary();
    valid_i = 1'b1;
    data_i  = {16'h4000, 16'h4000};
    mute_i  = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    check("mute_hold_full", 32'(ready_o), 32'h0);
    wait_pre_boundary("mute_align");
    @(negedge clk_i);
    check("mute_hold_drained", 32'(ready_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      repeat (CLK_DIV) @(negedge clk_i);
      d[i] = dout_o;
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("mute_alternate%0d", i), 32'(d[i] ^ d[i+1]), 32'h3);
    mute_i = 1'b0;

    // Reset mid-frame with hold full and underrun set.
    repeat (CLK_DIV * OSR + 4) @(negedge clk_i);
    avoid_boundary();
    fr = {16'h1111, 16'h2222};
    valid_i = 1'b1;
    data_i  = fr;
    @(negedge clk_i);
    valid_i = 1'b0;
    check("midrst_hold_full", 32'(ready_o), 32'h0);
    rst_i = 1'b1;
    #1;
    check("midrst_dout", 32'(dout_o), 32'h0);
    check("midrst_underrun", 32'(underrun_o), 32'h0);
    check("midrst_ready", 32'(ready_o), 32'h1);
    @(negedge clk_i);
    rst_i   = 1'b0;
    valid_i = 1'b1;
    check("postrst_ready", 32'(ready_o), 32'h1);
    @(negedge clk_i);
    valid_i = 1'b0;
    check("postrst_accepted", 32'(ready_o), 32'h0);

    n = 0;
    repeat (CLK_DIV * OSR * 3) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
